// File: rtl/hero_ctl_unit.sv
// Frame-rate motion controller for the two mirrored heroes: keys, collision gating, clamping and win detect.
// Optional HERO_DIAG_EN lets both axes move on the same frame tick.
module hero_ctl_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        next_level,
    input  logic        vsync_in,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        key_up,
    input  logic        key_down,
    input  logic [7:0]  collision,
    output logic [23:0] hero_x_pos,
    output logic [23:0] hero_y_pos,
    output logic        level_done
);

    localparam int unsigned POS_W       = 12;
    localparam int unsigned EXT_W       = POS_W + 1;
    localparam int unsigned STEP        = 1;
    localparam int unsigned SQUARE_SIDE = 60;
    localparam int unsigned X_MIN       = 61;
    localparam int unsigned X_MAX       = 901;
    localparam int unsigned Y_MIN       = 108;
    localparam int unsigned Y_MAX       = 648;
    localparam int unsigned H0_X0       = 61;
    localparam int unsigned H0_Y0       = 648;
    localparam int unsigned H1_X0       = 901;
    localparam int unsigned H1_Y0       = 648;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               vsync_d;
    logic               level_done_d;
    logic [POS_W-1:0]   x0_q, x1_q, y0_q, y1_q;
    logic [POS_W-1:0]   x0_d, x1_d, y0_d, y1_d;
    logic [POS_W-1:0]   x_diff;
    logic               tick, meet;
    logic               up_e, down_e, left_e, right_e;
    logic               mv_up, mv_down, mv_left, mv_right;

    // Step toward a lower bound; compares before subtracting so it never wraps.
    function automatic logic [POS_W-1:0] step_dec(input logic [POS_W-1:0] pos,
                                                  input logic [POS_W-1:0] lo);
        if ({1'b0, pos} >= ({1'b0, lo} + EXT_W'(STEP)))
            step_dec = pos - POS_W'(STEP);
        else
            step_dec = lo;
    endfunction

    function automatic logic [POS_W-1:0] step_inc(input logic [POS_W-1:0] pos,
                                                  input logic [POS_W-1:0] hi);
        if (({1'b0, pos} + EXT_W'(STEP)) <= {1'b0, hi})
            step_inc = pos + POS_W'(STEP);
        else
            step_inc = hi;
    endfunction

    assign tick   = vsync_in & ~vsync_d;
    assign x_diff = (x0_q >= x1_q) ? (x0_q - x1_q) : (x1_q - x0_q);
    assign meet   = (y0_q == y1_q) && (x_diff <= POS_W'(SQUARE_SIDE));

    assign up_e    = key_up    & ~key_down;
    assign down_e  = key_down  & ~key_up;
    assign left_e  = key_left  & ~key_right;
    assign right_e = key_right & ~key_left;

`ifdef HERO_DIAG_EN
    assign mv_up    = up_e;
    assign mv_down  = down_e;
    assign mv_left  = left_e;
    assign mv_right = right_e;
`else
    // One axis per tick: a vertical request, even if blocked, consumes the tick.
    assign mv_up    = up_e;
    assign mv_down  = down_e;
    assign mv_left  = left_e  & ~(up_e | down_e);
    assign mv_right = right_e & ~(up_e | down_e);
`endif

    // Next-state, next-position and level_done logic.
    always_comb begin
        state_d      = state_q;
        x0_d         = x0_q;
        x1_d         = x1_q;
        y0_d         = y0_q;
        y1_d         = y1_q;
        level_done_d = level_done;

        if (next_level) begin
            state_d      = ST_INIT;
            x0_d         = POS_W'(H0_X0);
            x1_d         = POS_W'(H1_X0);
            y0_d         = POS_W'(H0_Y0);
            y1_d         = POS_W'(H1_Y0);
            level_done_d = 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    state_d      = ST_PLAY;
                    x0_d         = POS_W'(H0_X0);
                    x1_d         = POS_W'(H1_X0);
                    y0_d         = POS_W'(H0_Y0);
                    y1_d         = POS_W'(H1_Y0);
                    level_done_d = 1'b0;
                end
                ST_PLAY: begin
                    if (meet) begin
                        state_d      = ST_WIN;
                        level_done_d = 1'b1;
                    end else if (tick) begin
                        if (mv_up) begin
                            if (!collision[3]) y0_d = step_dec(y0_q, POS_W'(Y_MIN));
                            if (!collision[7]) y1_d = step_dec(y1_q, POS_W'(Y_MIN));
                        end else if (mv_down) begin
                            if (!collision[2]) y0_d = step_inc(y0_q, POS_W'(Y_MAX));
                            if (!collision[6]) y1_d = step_inc(y1_q, POS_W'(Y_MAX));
                        end
                        // Horizontal is mirrored: hero1 moves opposite to the key.
                        if (mv_left) begin
                            if (!collision[0]) x0_d = step_dec(x0_q, POS_W'(X_MIN));
                            if (!collision[5]) x1_d = step_inc(x1_q, POS_W'(X_MAX));
                        end else if (mv_right) begin
                            if (!collision[1]) x0_d = step_inc(x0_q, POS_W'(X_MAX));
                            if (!collision[4]) x1_d = step_dec(x1_q, POS_W'(X_MIN));
                        end
                    end
                end
                ST_WIN: begin
                    level_done_d = 1'b1;
                end
                default: begin
                    state_d      = ST_INIT;
                    level_done_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            vsync_d    <= 1'b0;
            level_done <= 1'b0;
            x0_q       <= POS_W'(H0_X0);
            x1_q       <= POS_W'(H1_X0);
            y0_q       <= POS_W'(H0_Y0);
            y1_q       <= POS_W'(H1_Y0);
        end else begin
            state_q    <= state_d;
            vsync_d    <= vsync_in;
            level_done <= level_done_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            y0_q       <= y0_d;
            y1_q       <= y1_d;
        end
    end

    assign hero_x_pos = {x1_q, x0_q};
    assign hero_y_pos = {y1_q, y0_q};

endmodule
